nw_path_decoder: RTL and testbench

- Consumes the traceback coordinate stream that the Needleman-Wunsch grid emits. The stream runs from the end cell (LENGTH-1, LENGTH-1) back to (0,0).
- Buffers the path in a LIFO and replays it in forward order as aligned character columns (char/char, char/gap, gap/char).
- Sits between the grid's traceback port and the host readout logic.

---
 rtl/nw_path_decoder.sv | 229 ++++++++++++++++++++++
 tb/tb_nw_path_decoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nw_path_decoder.sv
// Buffers the Needleman-Wunsch traceback stream in a LIFO and replays it as forward alignment columns.
// Optional feature macro NW_PATH_SCORE_EN adds a signed score accumulator and the score port.
module nw_path_decoder #(
  parameter int unsigned LENGTH      = 10,
  parameter int unsigned CWIDTH      = 2,
  parameter int unsigned CORD_LENGTH = 8,
  parameter int unsigned DEPTH       = 2*LENGTH
`ifdef NW_PATH_SCORE_EN
  ,
  parameter int unsigned SWIDTH      = 16,
  parameter int          MATCH       = 1,
  parameter int          MISMATCH    = -1,
  parameter int          INDEL       = -1
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LENGTH*CWIDTH-1:0] s1,
  input  logic [LENGTH*CWIDTH-1:0] s2,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CORD_LENGTH-1:0]   in_x,
  input  logic [CORD_LENGTH-1:0]   in_y,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CWIDTH-1:0]        out_c1,
  output logic [CWIDTH-1:0]        out_c2,
  output logic                     out_gap1,
  output logic                     out_gap2,
  output logic                     out_last,
  output logic                     err,
  output logic                     busy
`ifdef NW_PATH_SCORE_EN
  ,
  output logic signed [SWIDTH-1:0] score
`endif
);

  localparam int unsigned SW   = LENGTH * CWIDTH;
  localparam int unsigned EW   = 2 * CORD_LENGTH;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [EW-1:0]          mem_q [DEPTH];
  logic [CNTW-1:0]        count_q, count_d;
  logic                   first_q, first_d;
  logic                   err_q, err_d;
  logic [CORD_LENGTH-1:0] xp_q, xp_d, yp_q, yp_d;
  logic                   out_valid_q, out_valid_d;
  logic [CWIDTH-1:0]      out_c1_q, out_c1_d, out_c2_q, out_c2_d;
  logic                   out_gap1_q, out_gap1_d, out_gap2_q, out_gap2_d;
  logic                   out_last_q, out_last_d;
  logic                   push_en;
  logic [EW-1:0]          top;
  logic [CORD_LENGTH-1:0] pop_x, pop_y, dx, dy;
`ifdef NW_PATH_SCORE_EN
  logic signed [SWIDTH-1:0] score_q, score_d;
`endif

  // Character i of a packed string; out-of-range indices read as 0.
  function automatic logic [CWIDTH-1:0] get_char(input logic [SW-1:0] s,
                                                 input logic [CORD_LENGTH-1:0] idx);
    logic [SW-1:0] sh;
    sh = '0;
    if (32'(idx) < LENGTH) sh = s >> ((LENGTH - 1 - 32'(idx)) * CWIDTH);
    return sh[CWIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) state_q <= FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    first_d     = first_q;
    err_d       = err_q;
    xp_d        = xp_q;
    yp_d        = yp_q;
    out_valid_d = out_valid_q;
    out_c1_d    = out_c1_q;
    out_c2_d    = out_c2_q;
    out_gap1_d  = out_gap1_q;
    out_gap2_d  = out_gap2_q;
    out_last_d  = out_last_q;
    push_en     = 1'b0;
    top         = mem_q[AW'(count_q - CNTW'(1))];
    pop_x       = top[EW-1:CORD_LENGTH];
    pop_y       = top[CORD_LENGTH-1:0];
    dx          = pop_x - xp_q;
    dy          = pop_y - yp_q;
`ifdef NW_PATH_SCORE_EN
    score_d     = score_q;
`endif
    case (state_q)
      FILL: begin
        out_valid_d = 1'b0;
`ifdef NW_PATH_SCORE_EN
        score_d = '0;
`endif
        if (in_valid) begin
          if (count_q == '0 &&
              (in_x != CORD_LENGTH'(LENGTH - 1) || in_y != CORD_LENGTH'(LENGTH - 1)))
            err_d = 1'b1;
          if (count_q == CNTW'(DEPTH)) begin
            err_d = 1'b1;
          end else begin
            push_en = 1'b1;
            count_d = count_q + CNTW'(1);
          end
          if (in_last) begin
            state_d = DRAIN;
            if (in_x != '0 || in_y != '0) err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready && out_last_q) begin
          state_d     = FILL;
          first_d     = 1'b1;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          out_c1_d    = '0;
          out_c2_d    = '0;
          out_gap1_d  = 1'b0;
          out_gap2_d  = 1'b0;
        end else if (!out_valid_q || out_ready) begin
          if (count_q != '0) begin
            // Pop the top entry and classify the step against the previous coordinate.
            out_valid_d = 1'b1;
            count_d     = count_q - CNTW'(1);
            out_last_d  = (count_q == CNTW'(1));
            first_d     = 1'b0;
            xp_d        = pop_x;
            yp_d        = pop_y;
            out_c1_d    = '0;
            out_c2_d    = '0;
            out_gap1_d  = 1'b0;
            out_gap2_d  = 1'b0;
            if (first_q || (dx == CORD_LENGTH'(1) && dy == CORD_LENGTH'(1))) begin
              out_c1_d = get_char(s1, pop_y);
              out_c2_d = get_char(s2, pop_x);
            end else if (dx == '0 && dy == CORD_LENGTH'(1)) begin
              out_c1_d   = get_char(s1, pop_y);
              out_gap2_d = 1'b1;
            end else if (dx == CORD_LENGTH'(1) && dy == '0) begin
              out_c2_d   = get_char(s2, pop_x);
              out_gap1_d = 1'b1;
            end else begin
              err_d      = 1'b1;
              out_gap1_d = 1'b1;
              out_gap2_d = 1'b1;
            end
`ifdef NW_PATH_SCORE_EN
            if (out_gap1_d || out_gap2_d) score_d = score_q + SWIDTH'(INDEL);
            else if (out_c1_d == out_c2_d) score_d = score_q + SWIDTH'(MATCH);
            else                           score_d = score_q + SWIDTH'(MISMATCH);
`endif
          end else begin
            out_valid_d = 1'b0;
            if (!out_valid_q) begin
              state_d = FILL;
              first_d = 1'b1;
            end
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q     <= '0;
      first_q     <= 1'b1;
      err_q       <= 1'b0;
      xp_q        <= '0;
      yp_q        <= '0;
      out_valid_q <= 1'b0;
      out_c1_q    <= '0;
      out_c2_q    <= '0;
      out_gap1_q  <= 1'b0;
      out_gap2_q  <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef NW_PATH_SCORE_EN
      score_q     <= '0;
`endif
    end else begin
      count_q     <= count_d;
      first_q     <= first_d;
      err_q       <= err_d;
      xp_q        <= xp_d;
      yp_q        <= yp_d;
      out_valid_q <= out_valid_d;
      out_c1_q    <= out_c1_d;
      out_c2_q    <= out_c2_d;
      out_gap1_q  <= out_gap1_d;
      out_gap2_q  <= out_gap2_d;
      out_last_q  <= out_last_d;
`ifdef NW_PATH_SCORE_EN
      score_q     <= score_d;
`endif
    end
  end

  // LIFO storage needs no reset; the count alone defines valid entries.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[AW'(count_q)] <= {in_x, in_y};
  end

  assign in_ready  = (state_q == FILL);
  assign busy      = (state_q == DRAIN);
  assign out_valid = out_valid_q;
  assign out_c1    = out_c1_q;
  assign out_c2    = out_c2_q;
  assign out_gap1  = out_gap1_q;
  assign out_gap2  = out_gap2_q;
  assign out_last  = out_last_q;
  assign err       = err_q;
`ifdef NW_PATH_SCORE_EN
  assign score     = score_q;
`endif

endmodule

// File: tb/tb_nw_path_decoder.sv
// Self-checking bench for nw_path_decoder: directed paths plus random paths against a queue-based model.
module tb_nw_path_decoder;
  localparam int unsigned L  = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned CL = 8;
  localparam int unsigned D  = 2*L;

  typedef struct packed {logic [CL-1:0] x; logic [CL-1:0] y;} crd_t;
  typedef struct packed {logic [CW-1:0] c1; logic [CW-1:0] c2; logic g1; logic g2; logic last;} col_t;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, in_last, out_valid, out_ready;
  logic out_gap1, out_gap2, out_last, err, busy;
  logic [L*CW-1:0] s1, s2;
  logic [CL-1:0] in_x, in_y;
  logic [CW-1:0] out_c1, out_c2;
`ifdef NW_PATH_SCORE_EN
  logic signed [15:0] score;
`endif

  always #5 clk = ~clk;

  nw_path_decoder #(.LENGTH(L), .CWIDTH(CW), .CORD_LENGTH(CL), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .s1(s1), .s2(s2),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_c1(out_c1), .out_c2(out_c2),
    .out_gap1(out_gap1), .out_gap2(out_gap2), .out_last(out_last), .err(err), .busy(busy)
`ifdef NW_PATH_SCORE_EN
    , .score(score)
`endif
  );

  crd_t path_q[$];
  col_t exp_q[$];
  int   s1a[L], s2a[L];
  bit   exp_err;
  int   exp_score;
  int   tests, fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic crd_t cd(input int x, input int y);
    crd_t c;
    c.x = CL'(x);
    c.y = CL'(y);
    return c;
  endfunction

  function automatic int ch1(input int i);
    return (i >= 0 && i < int'(L)) ? s1a[i] : 0;
  endfunction

  function automatic int ch2(input int i);
    return (i >= 0 && i < int'(L)) ? s2a[i] : 0;
  endfunction

  task automatic set_strings();
    for (int i = 0; i < int'(L); i++) begin
      s1[((L-1)-i)*CW +: CW] = CW'(s1a[i]);
      s2[((L-1)-i)*CW +: CW] = CW'(s2a[i]);
    end
  endtask

  // Reference: keep the first DEPTH coordinates, walk them in forward order, classify each step.
  task automatic build_exp();
    crd_t kept[$];
    col_t c;
    int x, y, dx, dy, n;
    exp_q.delete();
    exp_score = 0;
    n = path_q.size();
    if (path_q[0] != cd(L-1, L-1)) exp_err = 1'b1;
    if (n > int'(D)) exp_err = 1'b1;
    if (path_q[n-1] != cd(0, 0)) exp_err = 1'b1;
    for (int i = 0; i < n && i < int'(D); i++) kept.push_back(path_q[i]);
    for (int k = kept.size() - 1; k >= 0; k--) begin
      c = '0;
      x = int'(kept[k].x);
      y = int'(kept[k].y);
      c.last = (k == 0);
      if (k == kept.size() - 1) begin
        c.c1 = CW'(ch1(y));
        c.c2 = CW'(ch2(x));
      end else begin
        dx = x - int'(kept[k+1].x);
        dy = y - int'(kept[k+1].y);
        if (dx == 1 && dy == 1) begin
          c.c1 = CW'(ch1(y));
          c.c2 = CW'(ch2(x));
        end else if (dx == 0 && dy == 1) begin
          c.c1 = CW'(ch1(y));
          c.g2 = 1'b1;
        end else if (dx == 1 && dy == 0) begin
          c.c2 = CW'(ch2(x));
          c.g1 = 1'b1;
        end else begin
          c.g1 = 1'b1;
          c.g2 = 1'b1;
          exp_err = 1'b1;
        end
      end
      exp_score += (c.g1 || c.g2) ? -1 : ((c.c1 == c.c2) ? 1 : -1);
      exp_q.push_back(c);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    reset = 1'b1;
    exp_err = 1'b0;
  endtask

  task automatic push_path();
    for (int i = 0; i < path_q.size(); i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_x = path_q[i].x;
      in_y = path_q[i].y;
      in_last = (i == path_q.size() - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("dead_cycle_valid", 32'(out_valid), 0);
    chk("drain_busy", 32'(busy), 1);
  endtask

  // mode 0: ready held high, 1: ready pattern 1-0-0-1, 2: random ready
  task automatic drain(input int mode, input int max_cols);
    int idx, cyc, first_v;
    bit done, stalled, rdy;
    col_t obs, held;
    idx = 0; cyc = 0; first_v = -1; done = 0; stalled = 0; held = '0;
    while (!done && idx < max_cols && cyc < 300) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      obs = {out_c1, out_c2, out_gap1, out_gap2, out_last};
      if (out_valid) begin
        if (first_v < 0) begin
          first_v = cyc;
          chk("first_valid_latency", 32'(cyc), 1);
        end
        if (stalled) chk("stall_hold", 32'(obs), 32'(held));
        if (rdy) begin
          if (idx < exp_q.size()) chk($sformatf("col%0d", idx), 32'(obs), 32'(exp_q[idx]));
          else chk("extra_col", 32'(idx), 32'(exp_q.size()));
`ifdef NW_PATH_SCORE_EN
          if (out_last) chk("score", 32'(score), 32'(exp_score));
`endif
          idx++;
          if (out_last) done = 1;
          stalled = 0;
        end else begin
          stalled = 1;
          held = obs;
        end
      end
      out_ready = rdy;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    if (max_cols >= 1000) begin
      chk("col_count", 32'(idx), 32'(exp_q.size()));
      chk("valid_after_last", 32'(out_valid), 0);
      chk("in_ready_after_last", 32'(in_ready), 1);
      chk("err", 32'(err), 32'(exp_err));
    end
  endtask

  task automatic gen_path();
    int x, y, r;
    path_q.delete();
    x = L - 1; y = L - 1;
    path_q.push_back(cd(x, y));
    while (x > 0 || y > 0) begin
      r = $urandom_range(0, 2);
      if (x > 0 && y > 0 && r == 0) begin x--; y--; end
      else if (x > 0 && (r == 1 || y == 0)) x--;
      else if (y > 0) y--;
      else x--;
      path_q.push_back(cd(x, y));
    end
  endtask

  initial begin
    tests = 0; fails = 0; exp_err = 1'b0;
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; s1 = '0; s2 = '0;
    do_reset("por");

    // ACGT vs ACGT, pure diagonal
    s1a = '{0, 1, 2, 3}; s2a = '{0, 1, 2, 3}; set_strings();
    path_q = '{cd(3,3), cd(2,2), cd(1,1), cd(0,0)};
    build_exp(); push_path(); drain(0, 1000);

    // gapped path
    path_q = '{cd(3,3), cd(3,2), cd(2,1), cd(1,0), cd(0,0)};
    build_exp(); push_path(); drain(0, 1000);

    // same path with back-pressure
    build_exp(); push_path(); drain(1, 1000);

    // bad start coordinate; err must remain set on a following clean path
    path_q = '{cd(2,3), cd(2,2), cd(1,1), cd(0,0)};
    build_exp(); push_path(); drain(0, 1000);
    path_q = '{cd(3,3), cd(2,2), cd(1,1), cd(0,0)};
    build_exp(); push_path(); drain(0, 1000);

    // jump (3,3)->(1,1)
    do_reset("rst_jump");
    path_q = '{cd(3,3), cd(1,1), cd(0,0)};
    build_exp(); push_path(); drain(0, 1000);

    // overflow: 2*L+1 coordinates before last
    do_reset("rst_ovf");
    path_q = '{cd(3,3), cd(3,2), cd(3,1), cd(3,0), cd(2,0), cd(1,0), cd(0,0),
               cd(0,0), cd(0,0), cd(0,0)};
    build_exp(); push_path(); drain(0, 1000);

    // reset in the middle of a drain, then a fresh path
    do_reset("rst_pre");
    path_q = '{cd(3,3), cd(3,2), cd(2,1), cd(1,0), cd(0,0)};
    build_exp(); push_path(); drain(0, 2);
    do_reset("rst_mid_drain");
    path_q = '{cd(3,3), cd(2,2), cd(1,1), cd(0,0)};
    build_exp(); push_path(); drain(0, 1000);

    // random strings, random valid paths, random back-pressure
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < int'(L); i++) begin
        s1a[i] = $urandom_range(0, 3);
        s2a[i] = $urandom_range(0, 3);
      end
      set_strings();
      gen_path();
      build_exp(); push_path(); drain(2, 1000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
